// File: rtl/mod_counter.sv
// mod_counter: modulo up/down event counter with prescaler, load/clear,
// wrap or saturate at the bounds, terminal-count pulse and sticky overflow.
module mod_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE = 1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [EXT_W-1:0] MAX_EXT  = EXT_W'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] psc_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic             ovf_set;
  logic             step;
  logic [EXT_W-1:0] out_ext;
  logic [EXT_W-1:0] load_ext;

  // Compare at WIDTH+1 bits so MAX_VAL at the top of the range behaves.
  assign out_ext  = {1'b0, out};
  assign load_ext = {1'b0, load_val};

  // Next-state: clear > load > step > hold; reset is applied in the register.
  always_comb begin
    out_nxt = out;
    psc_nxt = psc;
    tc_nxt  = 1'b0;
    ovf_set = 1'b0;
    step    = 1'b0;

    if (clear) begin
      out_nxt = '0;
      psc_nxt = '0;
    end else if (load) begin
      out_nxt = (load_ext > MAX_EXT) ? MAX_W : load_val;
      psc_nxt = '0;
    end else if (enable) begin
      if (psc == PSC_LAST) begin
        psc_nxt = '0;
        step    = 1'b1;
      end else begin
        psc_nxt = psc + PSC_W'(1);
      end
    end

    if (step) begin
      if (dir) begin
        if (out_ext < MAX_EXT) begin
          out_nxt = out + WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
          if (!SATURATE) begin
            out_nxt = '0;
            tc_nxt  = 1'b1;
          end
        end
      end else begin
        if (out_ext != '0) begin
          out_nxt = out - WIDTH'(1);
        end else begin
          ovf_set = 1'b1;
          if (!SATURATE) begin
            out_nxt = MAX_W;
            tc_nxt  = 1'b1;
          end
        end
      end
    end

    // A new overflow event outranks a simultaneous clear request.
    if (ovf_set) begin
      ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      ovf_nxt = 1'b0;
    end else begin
      ovf_nxt = ovf;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      psc <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= out_nxt;
      psc <= psc_nxt;
      tc  <= tc_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four configurations share one stimulus stream and
// are checked every cycle against an arithmetic model, plus literal checks.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset, enable, clear, load, dir, ovf_clr;
  logic [4:0] lv;

  logic [3:0] out_a, out_b, out_c;
  logic [2:0] out_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // A: wrap, no prescale. B: saturate, prescale 3. C: saturate, no prescale.
  // D: full 3-bit range, prescale 2, wrap.
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_val(lv[3:0]), .dir(dir), .ovf_clr(ovf_clr),
    .out(out_a), .tc(tc_a), .ovf(ovf_a));
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b1)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_val(lv[3:0]), .dir(dir), .ovf_clr(ovf_clr),
    .out(out_b), .tc(tc_b), .ovf(ovf_b));
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_val(lv[3:0]), .dir(dir), .ovf_clr(ovf_clr),
    .out(out_c), .tc(tc_c), .ovf(ovf_c));
  mod_counter #(.WIDTH(3), .MAX_VAL(7), .PRESCALE(2), .SATURATE(1'b0)) u_d (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_val(lv[2:0]), .dir(dir), .ovf_clr(ovf_clr),
    .out(out_d), .tc(tc_d), .ovf(ovf_d));

  int cfg_max [4] = '{9, 9, 9, 7};
  int cfg_psc [4] = '{1, 3, 1, 2};
  int cfg_sat [4] = '{0, 1, 1, 0};
  int cfg_mask[4] = '{15, 15, 15, 7};

  logic [31:0] dut_out[4];
  logic        dut_tc [4];
  logic        dut_ovf[4];

  always_comb begin
    dut_out[0] = 32'(out_a); dut_out[1] = 32'(out_b);
    dut_out[2] = 32'(out_c); dut_out[3] = 32'(out_d);
    dut_tc[0]  = tc_a;  dut_tc[1]  = tc_b;  dut_tc[2]  = tc_c;  dut_tc[3]  = tc_d;
    dut_ovf[0] = ovf_a; dut_ovf[1] = ovf_b; dut_ovf[2] = ovf_c; dut_ovf[3] = ovf_d;
  end

  // Model state: count value, enabled cycles since the last restart, flags.
  int m_out[4], m_en_cycles[4], m_tc[4], m_ovf[4];
  bit model_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, want);
    end
  endtask

  // Reference model: a step happens every PRESCALE-th enabled cycle counted
  // since the last reset/clear/load.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bit hit;
      int v;
      hit = 1'b0;
      if (reset) begin
        m_out[k] = 0; m_en_cycles[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      end else begin
        m_tc[k] = 0;
        if (clear) begin
          m_out[k] = 0; m_en_cycles[k] = 0;
        end else if (load) begin
          v = int'(lv) & cfg_mask[k];
          m_out[k] = (v > cfg_max[k]) ? cfg_max[k] : v;
          m_en_cycles[k] = 0;
        end else if (enable) begin
          m_en_cycles[k] = m_en_cycles[k] + 1;
          if (m_en_cycles[k] % cfg_psc[k] == 0) begin
            if (dir) begin
              if (m_out[k] < cfg_max[k]) m_out[k] = m_out[k] + 1;
              else begin
                hit = 1'b1;
                if (cfg_sat[k] == 0) begin m_out[k] = 0; m_tc[k] = 1; end
              end
            end else begin
              if (m_out[k] > 0) m_out[k] = m_out[k] - 1;
              else begin
                hit = 1'b1;
                if (cfg_sat[k] == 0) begin m_out[k] = cfg_max[k]; m_tc[k] = 1; end
              end
            end
          end
        end
        if (hit) m_ovf[k] = 1;
        else if (ovf_clr) m_ovf[k] = 0;
      end
    end
    if (reset) model_valid = 1'b1;
  end

  // Compare every instance against the model on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out%0d", k), dut_out[k], 32'(m_out[k]));
        chk($sformatf("tc%0d", k), {31'd0, dut_tc[k]}, 32'(m_tc[k]));
        chk($sformatf("ovf%0d", k), {31'd0, dut_ovf[k]}, 32'(m_ovf[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[4]  = '{1, 0, 0, 0};
  int exp_dov[4] = '{0, 0, 1, 1};

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b1; ovf_clr = 1'b0; lv = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_tc", {31'd0, tc_a}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_a}, 32'd0);

    // Wrap up on A; B steps every third edge.
    enable = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("wrap_out", 32'(out_a), 32'(exp_up[i-1]));
      chk("wrap_tc", {31'd0, tc_a}, (i == 10) ? 32'd1 : 32'd0);
      chk("wrap_ovf", {31'd0, ovf_a}, (i >= 10) ? 32'd1 : 32'd0);
      if (i % 3 == 0 && i <= 9) chk("psc_cadence", 32'(out_b), 32'(i / 3));
    end

    // Prescaler phase survives an enable gap on edges 8 and 9.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      enable = (i == 8 || i == 9) ? 1'b0 : 1'b1;
      tick();
      if (i == 7)  chk("psc_e7", 32'(out_b), 32'd2);
      if (i == 10) chk("psc_e10", 32'(out_b), 32'd2);
      if (i == 11) chk("psc_e11", 32'(out_b), 32'd3);
    end

    // Down into the saturating floor on C.
    enable = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    load = 1'b1; lv = 5'd2; tick(); load = 1'b0;
    chk("dn_load", 32'(out_c), 32'd2);
    dir = 1'b0; enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_out", 32'(out_c), 32'(exp_dn[i]));
      chk("dn_tc", {31'd0, tc_c}, 32'd0);
      chk("dn_ovf", {31'd0, ovf_c}, 32'(exp_dov[i]));
    end

    // clear beats load beats enable; load clamps to MAX_VAL.
    clear = 1'b1; load = 1'b1; lv = 5'd5; enable = 1'b1; tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    chk("prio_clear", 32'(out_a), 32'd0);
    load = 1'b1; lv = 5'd15; tick(); load = 1'b0;
    chk("load_clamp", 32'(out_a), 32'd9);

    // ovf_clr loses to a simultaneous wrap, then clears on a quiet cycle.
    ovf_clr = 1'b1; tick();
    chk("ovf_clr0", {31'd0, ovf_a}, 32'd0);
    enable = 1'b1; dir = 1'b1; tick();
    chk("ovf_set_wins", {31'd0, ovf_a}, 32'd1);
    chk("ovf_wrap_tc", {31'd0, tc_a}, 32'd1);
    chk("ovf_wrap_out", 32'(out_a), 32'd0);
    enable = 1'b0; tick();
    chk("ovf_cleared", {31'd0, ovf_a}, 32'd0);
    chk("tc_one_cycle", {31'd0, tc_a}, 32'd0);
    ovf_clr = 1'b0;

    // Reset mid-run on B with out=7, ovf=1 and psc nonzero.
    load = 1'b1; lv = 5'd0; tick(); load = 1'b0;
    dir = 1'b0; enable = 1'b1; repeat (3) tick();
    load = 1'b1; lv = 5'd7; enable = 1'b0; tick(); load = 1'b0;
    enable = 1'b1; tick();
    chk("pre_rst_out", 32'(out_b), 32'd7);
    chk("pre_rst_ovf", {31'd0, ovf_b}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_out", 32'(out_b), 32'd0);
    chk("mid_rst_tc", {31'd0, tc_b}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf_b}, 32'd0);
    dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("restart", 32'(out_b), (i == 3) ? 32'd1 : 32'd0);
    end

    // Random traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom % 256) == 0;
      clear   = ($urandom % 23) == 0;
      load    = ($urandom % 17) == 0;
      enable  = ($urandom % 10) < 7;
      if (($urandom % 8) == 0) dir = ~dir;
      ovf_clr = ($urandom % 9) == 0;
      lv      = 5'($urandom % 32);
      tick();
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter with optional prescaler, synchronous load and clear, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It generalises the team's fixed 8-bit free-running enable counter and is the standard event/timebase counter used inside control blocks. Everything is synchronous to a single clock.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (1..32)
- MAX_VAL, 2**WIDTH-1, terminal value; the count range is 0..MAX_VAL; must be at most 2**WIDTH-1
- PRESCALE, 1, number of enabled cycles per count step (1..65535); 1 means step on every enabled cycle
- SATURATE, 0, 0 means wrap at the bounds; 1 means hold at the bound

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  count qualifier; stepping occurs only while high
- clear  input  1  synchronous clear of the count and the prescaler
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  load value; values above MAX_VAL are clamped to MAX_VAL
- dir  input  1  1 means up, 0 means down; sampled on each step
- ovf_clr  input  1  clears ovf
- out  output  WIDTH  current count, registered
- tc  output  1  one-cycle pulse on wrap, registered
- ovf  output  1  sticky overflow/underflow flag, registered

## Operation
- Per-cycle priority: reset > clear > load > step > hold.
- reset: out=0, tc=0, ovf=0, prescaler=0.
- clear: out=0, prescaler=0, tc=0. ovf is not affected.
- load: out=min(load_val, MAX_VAL), prescaler=0, tc=0. load takes priority over enable in the same cycle.
- Prescaler (psc, width ceil(log2(PRESCALE)), minimum 1 bit):
  - When enable=1, psc advances 0..PRESCALE-1 and wraps.
  - A step fires on any cycle with enable=1 and psc==PRESCALE-1.
  - When enable=0, psc holds and no step fires.
- Step with dir=1:
  - If out<MAX_VAL: out+1.
  - If out==MAX_VAL and SATURATE=0: out becomes 0, tc pulses, ovf is set.
  - If out==MAX_VAL and SATURATE=1: out holds, tc=0, ovf is set.
- Step with dir=0:
  - If out>0: out-1.
  - If out==0 and SATURATE=0: out becomes MAX_VAL, tc pulses, ovf is set.
  - If out==0 and SATURATE=1: out holds, ovf is set, tc=0.
- Arithmetic is computed at WIDTH+1 bits internally. out never leaves 0..MAX_VAL, including when MAX_VAL is not a power-of-two boundary.
- ovf:
  - Set by any wrap or saturation attempt.
  - Cleared by ovf_clr.
  - If a set and ovf_clr occur in the same cycle, set wins.
- tc is low in every cycle that is not the first cycle after a wrapping step.

## Timing
- Latency: out, tc and ovf update on the clock edge that samples the step, clear, load or reset condition, i.e. they are visible one cycle after the inputs are applied.
- Step cadence with enable held continuously from reset: the first step is on edge PRESCALE, then every PRESCALE edges after that. With PRESCALE=1, out changes on every enabled edge.
- Dropping enable pauses the prescaler, and its phase is preserved. Re-asserting enable resumes from the stored psc.
- tc is high for exactly one cycle, coincident with out showing the wrapped value (0 going up, MAX_VAL going down).
- dir may change on any cycle and takes effect at the next step. Changing dir does not reset psc.
- Reset asserted mid-count forces all outputs to their reset values on the next edge, regardless of the other inputs.

## Test plan
- Wrap up: WIDTH=4, MAX_VAL=9, PRESCALE=1, SATURATE=0, enable=1, dir=1 for 12 cycles.
  - Required: out reads 1..9, 0, 1, 2.
  - tc=1 only in the cycle where out=0 after 9.
  - ovf=1 from that cycle onward.
- Down/saturate: SATURATE=1, MAX_VAL=9, load_val=2 with load=1, then dir=0 and enable=1 for 4 cycles.
  - Required: out reads 2, 1, 0, 0, 0.
  - tc never asserts.
  - ovf sets on the first held-at-0 step.
- Prescaler: PRESCALE=3, enable=1 from reset.
  - Required: out increments on edges 3, 6, 9.
  - Dropping enable for 2 cycles after edge 7 delays the next increment to edge 11.
- Priority: in one cycle assert clear, load (load_val=5) and enable together.
  - Required: out=0 next cycle.
  - Then load alone with load_val=15 and MAX_VAL=9: out=9.
- ovf handling: assert ovf_clr on the same cycle as a wrap step → ovf=1. ovf_clr on the next cycle with no step → ovf=0.
- Reset mid-run: with out=7, ovf=1 and psc nonzero, assert reset for one cycle with enable=1.
  - Required: out=0, tc=0, ovf=0.
  - The count then restarts with its first step PRESCALE edges later.
